alarm_led_driver: RTL and testbench

//   Downstream of the temperature-state stage. Consumes its 10-bit alarm pattern and

---
 rtl/alarm_led_driver_pkg.sv | 33 +++
 rtl/alarm_led_driver_blink_timer.sv | 56 +++++
 rtl/alarm_led_driver.sv | 142 ++++++++++++++
 tb/tb_alarm_led_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_led_driver_pkg.sv
// Shared constants for the alarm LED annunciator.
// State codes, severity codes and LED patterns.
package alarm_led_driver_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WARN     = 2'd1;
  localparam logic [1:0] ST_CRIT     = 2'd2;
  localparam logic [1:0] ST_ACK_HOLD = 2'd3;

  localparam logic [1:0] SEV_NONE = 2'd0;
  localparam logic [1:0] SEV_WARN = 2'd1;
  localparam logic [1:0] SEV_CRIT = 2'd2;

  localparam logic [9:0] PAT_OFF    = 10'h000;
  localparam logic [9:0] PAT_WARN_A = 10'h2AA;
  localparam logic [9:0] PAT_WARN_B = 10'h155;
  localparam logic [9:0] PAT_CRIT   = 10'h3FF;

  function automatic logic [1:0] classify(
    input logic [9:0] pat
  );
    logic [1:0] s;
    if (pat == PAT_OFF) begin
      s = SEV_NONE;
    end else if (pat == PAT_CRIT) begin
      s = SEV_CRIT;
    end else begin
      s = SEV_WARN;
    end
    return s;
  endfunction

endpackage

// File: rtl/alarm_led_driver_blink_timer.sv
// Half-period blink timer with slow/fast terminal count.
// Clear restarts the count with phase high.
module blink_timer #(
  parameter int SLOW_HALF = 8,
  parameter int FAST_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic fast,
  output logic tc,
  output logic phase
);

  localparam int TW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
  localparam logic [TW-1:0] SLOW_TC = TW'(SLOW_HALF - 1);
  localparam logic [TW-1:0] FAST_TC = TW'(FAST_HALF - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          phase_q, phase_d;
  logic [TW-1:0] tc_val;

  assign tc_val = fast ? FAST_TC : SLOW_TC;
  assign tc     = en & ~clear & (timer_q == tc_val);
  assign phase  = phase_q;

  always_comb begin
    timer_d = timer_q;
    phase_d = phase_q;
    if (clear) begin
      timer_d = '0;
      phase_d = 1'b1;
    end else if (en) begin
      if (timer_q == tc_val) begin
        timer_d = '0;
        phase_d = ~phase_q;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      phase_q <= 1'b1;
    end else begin
      timer_q <= timer_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/alarm_led_driver.sv
// Latched, blinking LED annunciator for the 10-bit alarm pattern.
// FSM, severity latch and registered LED mux.
module alarm_led_driver
  import alarm_led_driver_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int SLOW_HZ = 1,
  parameter int FAST_HZ = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] alarm_in,
  input  logic       ack,
  output logic [9:0] led,
  output logic       alarm_active,
  output logic [1:0] severity
);

  localparam int SLOW_HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int FAST_HALF = CLK_HZ / (2 * FAST_HZ);

  logic [9:0] alarm_q;
  logic [1:0] state_q, state_d;
  logic [1:0] lsev_q, lsev_d;
  logic [9:0] led_q, led_d;
  logic       act_q, act_d;
  logic [1:0] sev_out_q;
  logic       upd_q, upd_d;
  logic [1:0] sev;
  logic       entry;
  logic       blink_en;
  logic       blink_fast;
  logic       blink_tc;
  logic       phase;
  logic [9:0] pat;

  assign sev        = classify(alarm_q);
  assign entry      = (state_d != state_q);
  assign blink_en   = (state_q == ST_WARN) | (state_q == ST_CRIT);
  assign blink_fast = (state_q == ST_CRIT);

  blink_timer #(
    .SLOW_HALF(SLOW_HALF),
    .FAST_HALF(FAST_HALF)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .clear(entry),
    .en   (blink_en),
    .fast (blink_fast),
    .tc   (blink_tc),
    .phase(phase)
  );

  // Escalation is checked before ack so a coincident ack is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sev == SEV_CRIT) begin
          state_d = ST_CRIT;
        end else if (sev == SEV_WARN) begin
          state_d = ST_WARN;
        end
      end
      ST_WARN: begin
        if (sev == SEV_CRIT) begin
          state_d = ST_CRIT;
        end else if (ack) begin
          state_d = (sev != SEV_NONE) ? ST_ACK_HOLD : ST_IDLE;
        end
      end
      ST_CRIT: begin
        if (ack) begin
          state_d = (sev != SEV_NONE) ? ST_ACK_HOLD : ST_IDLE;
        end
      end
      ST_ACK_HOLD: begin
        if (sev == SEV_NONE) begin
          state_d = ST_IDLE;
        end else if (sev > lsev_q) begin
          state_d = ST_CRIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lsev_d = lsev_q;
    if (entry) begin
      unique case (state_d)
        ST_WARN: lsev_d = SEV_WARN;
        ST_CRIT: lsev_d = SEV_CRIT;
        ST_IDLE: lsev_d = SEV_NONE;
        default: lsev_d = lsev_q;
      endcase
    end
  end

  always_comb begin
    pat = PAT_OFF;
    unique case (state_q)
      ST_WARN:     pat = phase ? PAT_WARN_A : PAT_WARN_B;
      ST_CRIT:     pat = phase ? PAT_CRIT : PAT_OFF;
      ST_ACK_HOLD: pat = (lsev_q == SEV_CRIT) ? PAT_CRIT : PAT_WARN_A;
      default:     pat = PAT_OFF;
    endcase
  end

  // The LED register only reloads after a state change or a phase flip.
  always_comb begin
    upd_d = entry | blink_tc;
    led_d = upd_q ? pat : led_q;
    act_d = blink_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q   <= '0;
      state_q   <= ST_IDLE;
      lsev_q    <= SEV_NONE;
      led_q     <= PAT_OFF;
      act_q     <= 1'b0;
      sev_out_q <= SEV_NONE;
      upd_q     <= 1'b0;
    end else begin
      alarm_q   <= alarm_in;
      state_q   <= state_d;
      lsev_q    <= lsev_d;
      led_q     <= led_d;
      act_q     <= act_d;
      sev_out_q <= lsev_q;
      upd_q     <= upd_d;
    end
  end

  assign led          = led_q;
  assign alarm_active = act_q;
  assign severity     = sev_out_q;

endmodule

// File: tb/tb_alarm_led_driver.sv
// Directed self-checking bench for alarm_led_driver.
// Small clock parameters: slow half 8, fast half 2.
module tb_alarm_led_driver;

  logic       clk;
  logic       rst;
  logic [9:0] alarm_in;
  logic       ack;
  logic [9:0] led;
  logic       alarm_active;
  logic [1:0] severity;

  int vectors;
  int miscompares;

  alarm_led_driver #(
    .CLK_HZ (16),
    .SLOW_HZ(1),
    .FAST_HZ(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alarm_in    (alarm_in),
    .ack         (ack),
    .led         (led),
    .alarm_active(alarm_active),
    .severity    (severity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alarm_in = 10'h000;
    ack = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    logic [9:0] exp_led;
    @(negedge clk);
    rst = 1'b1;
    alarm_in = 10'h3FF;
    ack = 1'b0;
    #1;
    exp_led = 10'h000;
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b0 || severity !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_held: led=%h act=%b sev=%0d want led=%h act=0 sev=0",
               led, alarm_active, severity, exp_led);
    end
    step(2);
    alarm_in = 10'h000;
    rst = 1'b0;
    step(3);
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b0 || severity !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_idle: led=%h act=%b sev=%0d want led=%h act=0 sev=0",
               led, alarm_active, severity, exp_led);
    end
  endtask

  task automatic test_warn_blink();
    logic [9:0] exp_led;
    do_reset();
    alarm_in = 10'h2AA;
    step(2);
    for (int k = 3; k <= 19; k++) begin
      step(1);
      exp_led = (((k - 3) / 8) % 2 == 0) ? 10'h2AA : 10'h155;
      vectors++;
      if (led !== exp_led || alarm_active !== 1'b1 || severity !== 2'd1) begin
        miscompares++;
        $display("FAIL warn_blink k=%0d: led=%h act=%b sev=%0d want led=%h act=1 sev=1",
                 k, led, alarm_active, severity, exp_led);
      end
    end
  endtask

  task automatic test_crit_flash();
    logic [9:0] exp_led;
    do_reset();
    alarm_in = 10'h3FF;
    step(2);
    for (int k = 3; k <= 12; k++) begin
      step(1);
      exp_led = (((k - 3) / 2) % 2 == 0) ? 10'h3FF : 10'h000;
      vectors++;
      if (led !== exp_led || alarm_active !== 1'b1 || severity !== 2'd2) begin
        miscompares++;
        $display("FAIL crit_flash k=%0d: led=%h act=%b sev=%0d want led=%h act=1 sev=2",
                 k, led, alarm_active, severity, exp_led);
      end
    end
  endtask

  task automatic test_warn_latch_ack();
    logic [9:0] exp_led;
    do_reset();
    alarm_in = 10'h2AA;
    step(4);
    alarm_in = 10'h000;
    for (int k = 5; k <= 44; k++) begin
      step(1);
      exp_led = (((k - 3) / 8) % 2 == 0) ? 10'h2AA : 10'h155;
      vectors++;
      if (led !== exp_led || alarm_active !== 1'b1) begin
        miscompares++;
        $display("FAIL warn_latched k=%0d: led=%h act=%b want led=%h act=1",
                 k, led, alarm_active, exp_led);
      end
    end
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    exp_led = 10'h000;
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b0 || severity !== 2'd0) begin
      miscompares++;
      $display("FAIL warn_ack_idle: led=%h act=%b sev=%0d want led=%h act=0 sev=0",
               led, alarm_active, severity, exp_led);
    end
  endtask

  task automatic test_crit_ack_hold();
    logic [9:0] exp_led;
    do_reset();
    alarm_in = 10'h3FF;
    step(4);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    exp_led = 10'h3FF;
    for (int k = 0; k < 6; k++) begin
      step(1);
      vectors++;
      if (led !== exp_led || alarm_active !== 1'b0 || severity !== 2'd2) begin
        miscompares++;
        $display("FAIL crit_hold k=%0d: led=%h act=%b sev=%0d want led=%h act=0 sev=2",
                 k, led, alarm_active, severity, exp_led);
      end
    end
    alarm_in = 10'h000;
    step(3);
    exp_led = 10'h000;
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b0 || severity !== 2'd0) begin
      miscompares++;
      $display("FAIL hold_clear: led=%h act=%b sev=%0d want led=%h act=0 sev=0",
               led, alarm_active, severity, exp_led);
    end
  endtask

  task automatic test_escalation();
    logic [9:0] exp_led;
    do_reset();
    alarm_in = 10'h2AA;
    step(4);
    alarm_in = 10'h3FF;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    exp_led = 10'h3FF;
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b1 || severity !== 2'd2) begin
      miscompares++;
      $display("FAIL esc_ack_drop: led=%h act=%b sev=%0d want led=%h act=1 sev=2",
               led, alarm_active, severity, exp_led);
    end
    step(2);
    exp_led = 10'h000;
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b1) begin
      miscompares++;
      $display("FAIL esc_flashing: led=%h act=%b want led=%h act=1",
               led, alarm_active, exp_led);
    end
    do_reset();
    alarm_in = 10'h2AA;
    step(4);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    exp_led = 10'h2AA;
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b0 || severity !== 2'd1) begin
      miscompares++;
      $display("FAIL warn_hold: led=%h act=%b sev=%0d want led=%h act=0 sev=1",
               led, alarm_active, severity, exp_led);
    end
    alarm_in = 10'h3FF;
    step(3);
    exp_led = 10'h3FF;
    vectors++;
    if (led !== exp_led || alarm_active !== 1'b1 || severity !== 2'd2) begin
      miscompares++;
      $display("FAIL hold_realarm: led=%h act=%b sev=%0d want led=%h act=1 sev=2",
               led, alarm_active, severity, exp_led);
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] exp_led;
    do_reset();
    alarm_in = 10'h3FF;
    step(3);
    exp_led = 10'h3FF;
    vectors++;
    if (led !== exp_led || severity !== 2'd2) begin
      miscompares++;
      $display("FAIL pre_async: led=%h sev=%0d want led=%h sev=2",
               led, severity, exp_led);
    end
    #2;
    rst = 1'b1;
    #1;
    exp_led = 10'h000;
    vectors++;
    if (led !== exp_led || severity !== 2'd0 || alarm_active !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: led=%h act=%b sev=%0d want led=%h act=0 sev=0",
               led, alarm_active, severity, exp_led);
    end
    alarm_in = 10'h000;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    alarm_in = 10'h000;
    ack = 1'b0;
    test_reset();
    test_warn_blink();
    test_crit_flash();
    test_warn_latch_ack();
    test_crit_ack_hold();
    test_escalation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
